// File: rtl/control_unit_pipe.sv
// Registered ID/EX control unit: decodes opcode/funct into a control word and adds
// stall hold, flush bubbles, load-use hazard detection and a RUN/HALT state machine.
module control_unit_pipe #(
  parameter int unsigned      NB_OP       = 6,
  parameter int unsigned      NB_FUNCT    = 6,
  parameter int unsigned      NB_REG      = 5,
  parameter logic [NB_OP-1:0] HALT_OPCODE = 6'b111111,
  parameter bit               HAZARD_EN   = 1'b1
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  input  logic                i_valid,
  input  logic [NB_OP-1:0]    i_opcode,
  input  logic [NB_FUNCT-1:0] i_funct,
  input  logic [NB_REG-1:0]   i_rs,
  input  logic [NB_REG-1:0]   i_rt,
  input  logic                i_stall,
  input  logic                i_flush,
  input  logic                i_resume,
  output logic                o_valid,
  output logic                o_alu_src,
  output logic [1:0]          o_reg_dst,
  output logic                o_reg_write,
  output logic                o_mem_read,
  output logic                o_mem_write,
  output logic                o_mem_to_reg,
  output logic                o_beq,
  output logic                o_bne,
  output logic                o_jump,
  output logic                o_jump_reg,
  output logic                o_link,
  output logic [1:0]          o_ext_mode,
  output logic [2:0]          o_word_size,
  output logic                o_hazard_stall,
  output logic                o_halted
);

  localparam logic [NB_OP-1:0] OpRtype = NB_OP'(6'b000000);
  localparam logic [NB_OP-1:0] OpJ     = NB_OP'(6'b000010);
  localparam logic [NB_OP-1:0] OpJal   = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OpBeq   = NB_OP'(6'b000100);
  localparam logic [NB_OP-1:0] OpBne   = NB_OP'(6'b000101);
  localparam logic [NB_OP-1:0] OpAddi  = NB_OP'(6'b001000);
  localparam logic [NB_OP-1:0] OpSlti  = NB_OP'(6'b001010);
  localparam logic [NB_OP-1:0] OpAndi  = NB_OP'(6'b001100);
  localparam logic [NB_OP-1:0] OpOri   = NB_OP'(6'b001101);
  localparam logic [NB_OP-1:0] OpXori  = NB_OP'(6'b001110);
  localparam logic [NB_OP-1:0] OpLui   = NB_OP'(6'b001111);
  localparam logic [NB_OP-1:0] OpLb    = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OpLh    = NB_OP'(6'b100001);
  localparam logic [NB_OP-1:0] OpLw    = NB_OP'(6'b100011);
  localparam logic [NB_OP-1:0] OpLbu   = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OpLhu   = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OpSb    = NB_OP'(6'b101000);
  localparam logic [NB_OP-1:0] OpSh    = NB_OP'(6'b101001);
  localparam logic [NB_OP-1:0] OpSw    = NB_OP'(6'b101011);

  localparam logic [NB_FUNCT-1:0] FnJr   = NB_FUNCT'(6'b001000);
  localparam logic [NB_FUNCT-1:0] FnJalr = NB_FUNCT'(6'b001001);

  localparam logic [0:0] StRun  = 1'b0;
  localparam logic [0:0] StHalt = 1'b1;

  typedef struct packed {
    logic       alu_src;
    logic [1:0] reg_dst;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       beq;
    logic       bne;
    logic       jump;
    logic       jump_reg;
    logic       link;
    logic [1:0] ext_mode;
    logic [2:0] word_size;
  } ctrl_t;

  ctrl_t             dec_ctrl;
  logic              dec_reads_rt;

  logic              valid_q, valid_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [NB_REG-1:0] load_rt_q, load_rt_d;
  logic [0:0]        state_q, state_d;

  logic              hazard;
  logic              halt_req;

  // Combinational decode of the instruction currently in ID.
  always_comb begin
    dec_ctrl     = '0;
    dec_reads_rt = 1'b0;
    case (i_opcode)
      OpRtype: begin
        dec_ctrl.reg_dst   = 2'b01;
        dec_ctrl.reg_write = 1'b1;
        dec_reads_rt       = 1'b1;
        if (i_funct == FnJr) begin
          dec_ctrl.jump_reg  = 1'b1;
          dec_ctrl.reg_write = 1'b0;
        end else if (i_funct == FnJalr) begin
          dec_ctrl.jump_reg = 1'b1;
          dec_ctrl.link     = 1'b1;
        end
      end
      OpAddi, OpSlti: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.reg_write = 1'b1;
      end
      OpAndi, OpOri, OpXori: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.ext_mode  = 2'b01;
        dec_ctrl.reg_write = 1'b1;
      end
      OpLui: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.ext_mode  = 2'b10;
        dec_ctrl.reg_write = 1'b1;
      end
      OpLb, OpLh, OpLw, OpLbu, OpLhu: begin
        dec_ctrl.alu_src    = 1'b1;
        dec_ctrl.mem_read   = 1'b1;
        dec_ctrl.mem_to_reg = 1'b1;
        dec_ctrl.reg_write  = 1'b1;
        case (i_opcode)
          OpLb:    dec_ctrl.word_size = 3'b001;
          OpLh:    dec_ctrl.word_size = 3'b010;
          OpLw:    dec_ctrl.word_size = 3'b011;
          OpLbu:   dec_ctrl.word_size = 3'b101;
          default: dec_ctrl.word_size = 3'b110;
        endcase
      end
      OpSb, OpSh, OpSw: begin
        dec_ctrl.alu_src   = 1'b1;
        dec_ctrl.mem_write = 1'b1;
        dec_reads_rt       = 1'b1;
        case (i_opcode)
          OpSb:    dec_ctrl.word_size = 3'b001;
          OpSh:    dec_ctrl.word_size = 3'b010;
          default: dec_ctrl.word_size = 3'b011;
        endcase
      end
      OpBeq: begin
        dec_ctrl.beq = 1'b1;
        dec_reads_rt = 1'b1;
      end
      OpBne: begin
        dec_ctrl.bne = 1'b1;
        dec_reads_rt = 1'b1;
      end
      OpJ: begin
        dec_ctrl.jump = 1'b1;
      end
      OpJal: begin
        dec_ctrl.jump      = 1'b1;
        dec_ctrl.link      = 1'b1;
        dec_ctrl.reg_write = 1'b1;
        dec_ctrl.reg_dst   = 2'b10;
      end
      default: begin
        dec_ctrl = '0;
      end
    endcase
  end

  // Load in EX whose destination is a source of the instruction in ID.
  always_comb begin
    hazard = 1'b0;
    if (HAZARD_EN && valid_q && ctrl_q.mem_read && (load_rt_q != '0) && i_valid &&
        (state_q == StRun)) begin
      hazard = (load_rt_q == i_rs) || (dec_reads_rt && (load_rt_q == i_rt));
    end
  end

  assign halt_req = i_valid && (i_opcode == HALT_OPCODE) && (state_q == StRun);

  always_comb begin
    valid_d   = valid_q;
    ctrl_d    = ctrl_q;
    load_rt_d = load_rt_q;
    state_d   = state_q;

    if (i_flush || hazard) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      load_rt_d = '0;
    end else if (i_stall) begin
      valid_d   = valid_q;
    end else if (state_q == StHalt) begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      load_rt_d = '0;
    end else if (halt_req) begin
      // The HALT instruction itself never reaches EX.
      valid_d   = 1'b0;
      ctrl_d    = '0;
      load_rt_d = '0;
      state_d   = StHalt;
    end else if (i_valid) begin
      valid_d   = 1'b1;
      ctrl_d    = dec_ctrl;
      load_rt_d = i_rt;
    end else begin
      valid_d   = 1'b0;
      ctrl_d    = '0;
      load_rt_d = '0;
    end

    if ((state_q == StHalt) && i_resume) begin
      state_d = StRun;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      valid_q   <= 1'b0;
      ctrl_q    <= '0;
      load_rt_q <= '0;
      state_q   <= StRun;
    end else begin
      valid_q   <= valid_d;
      ctrl_q    <= ctrl_d;
      load_rt_q <= load_rt_d;
      state_q   <= state_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_alu_src      = ctrl_q.alu_src;
  assign o_reg_dst      = ctrl_q.reg_dst;
  assign o_reg_write    = ctrl_q.reg_write;
  assign o_mem_read     = ctrl_q.mem_read;
  assign o_mem_write    = ctrl_q.mem_write;
  assign o_mem_to_reg   = ctrl_q.mem_to_reg;
  assign o_beq          = ctrl_q.beq;
  assign o_bne          = ctrl_q.bne;
  assign o_jump         = ctrl_q.jump;
  assign o_jump_reg     = ctrl_q.jump_reg;
  assign o_link         = ctrl_q.link;
  assign o_ext_mode     = ctrl_q.ext_mode;
  assign o_word_size    = ctrl_q.word_size;
  assign o_hazard_stall = hazard;
  assign o_halted       = (state_q == StHalt);

endmodule

// File: tb/tb_control_unit_pipe.sv
// Randomized bench for control_unit_pipe against a table-driven pipeline model,
// with directed sequences pinning reset, load-use, stall/flush and HALT behaviour.
module tb_control_unit_pipe;

  logic       i_clk, i_reset_n, i_valid, i_stall, i_flush, i_resume;
  logic [5:0] i_opcode, i_funct;
  logic [4:0] i_rs, i_rt;
  logic       o_valid, o_alu_src, o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg;
  logic       o_beq, o_bne, o_jump, o_jump_reg, o_link, o_hazard_stall, o_halted;
  logic [1:0] o_reg_dst, o_ext_mode;
  logic [2:0] o_word_size;

  control_unit_pipe dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_funct(i_funct), .i_rs(i_rs), .i_rt(i_rt), .i_stall(i_stall), .i_flush(i_flush),
    .i_resume(i_resume), .o_valid(o_valid), .o_alu_src(o_alu_src), .o_reg_dst(o_reg_dst),
    .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_to_reg(o_mem_to_reg), .o_beq(o_beq), .o_bne(o_bne), .o_jump(o_jump),
    .o_jump_reg(o_jump_reg), .o_link(o_link), .o_ext_mode(o_ext_mode),
    .o_word_size(o_word_size), .o_hazard_stall(o_hazard_stall), .o_halted(o_halted)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // {valid, alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg,
  //  beq, bne, jump, jump_reg, link, ext_mode, word_size}
  logic [17:0] dut_w;
  assign dut_w = {o_valid, o_alu_src, o_reg_dst, o_reg_write, o_mem_read, o_mem_write,
                  o_mem_to_reg, o_beq, o_bne, o_jump, o_jump_reg, o_link, o_ext_mode,
                  o_word_size};

  int n_vec = 0;
  int n_err = 0;

  logic [5:0]  tab_op [20];
  logic [16:0] tab_w  [20];
  int          tab_n = 0;

  logic [17:0] m_word;
  logic [4:0]  m_lrt;
  bit          m_halt;

  function automatic logic [16:0] mk(bit alu, logic [1:0] dst, bit rw, bit mr, bit mw,
                                     bit m2r, bit bq, bit bn, bit j, bit jr, bit lk,
                                     logic [1:0] ext, logic [2:0] ws);
    return {alu, dst, rw, mr, mw, m2r, bq, bn, j, jr, lk, ext, ws};
  endfunction

  task automatic add(input logic [5:0] op, input logic [16:0] w);
    tab_op[tab_n] = op;
    tab_w[tab_n]  = w;
    tab_n++;
  endtask

  task automatic build_table();
    add(6'b001000, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // ADDI
    add(6'b001010, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));  // SLTI
    add(6'b001100, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));  // ANDI
    add(6'b001101, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));  // ORI
    add(6'b001110, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));  // XORI
    add(6'b001111, mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));  // LUI
    add(6'b100000, mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1));  // LB
    add(6'b100001, mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 2));  // LH
    add(6'b100011, mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 3));  // LW
    add(6'b100100, mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 5));  // LBU
    add(6'b100101, mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 6));  // LHU
    add(6'b101000, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1));  // SB
    add(6'b101001, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 2));  // SH
    add(6'b101011, mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3));  // SW
    add(6'b000100, mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));  // BEQ
    add(6'b000101, mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));  // BNE
    add(6'b000010, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0));  // J
    add(6'b000011, mk(0, 2, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0));  // JAL
  endtask

  function automatic logic [16:0] model_decode(logic [5:0] op, logic [5:0] fn);
    if (op == 6'b000000) begin
      if (fn == 6'b001000) return mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      if (fn == 6'b001001) return mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      return mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    end
    for (int k = 0; k < tab_n; k++) if (tab_op[k] == op) return tab_w[k];
    return '0;
  endfunction

  function automatic bit reads_rt(logic [5:0] op);
    return op inside {6'b000000, 6'b000100, 6'b000101, 6'b101000, 6'b101001, 6'b101011};
  endfunction

  task automatic chk(input string name, input logic [17:0] act, input logic [17:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_word = '0;
    m_lrt  = '0;
    m_halt = 1'b0;
  endtask

  // One cycle: drive inputs while the clock is low, check the combinational stall,
  // advance the model across the rising edge and check the registered outputs.
  task automatic step(input logic v, input logic [5:0] op, input logic [5:0] fn,
                      input logic [4:0] rs, input logic [4:0] rt, input logic st,
                      input logic fl, input logic rsm, output logic hz_dut);
    logic [17:0] nw;
    logic [4:0]  nl;
    bit          nh, hz;
    i_valid = v; i_opcode = op; i_funct = fn; i_rs = rs; i_rt = rt;
    i_stall = st; i_flush = fl; i_resume = rsm;
    #1;
    hz = m_word[17] && m_word[12] && (m_lrt != 0) && v && !m_halt &&
         ((m_lrt == rs) || ((m_lrt == rt) && reads_rt(op)));
    hz_dut = o_hazard_stall;
    chk("hazard_stall", {17'b0, o_hazard_stall}, {17'b0, hz});
    nw = m_word; nl = m_lrt; nh = m_halt;
    if (fl || hz) begin
      nw = '0; nl = '0;
    end else if (st) begin
      nw = m_word;
    end else if (m_halt) begin
      nw = '0; nl = '0;
    end else if (v && op == 6'b111111) begin
      nw = '0; nl = '0; nh = 1'b1;
    end else if (v) begin
      nw = {1'b1, model_decode(op, fn)}; nl = rt;
    end else begin
      nw = '0; nl = '0;
    end
    if (m_halt && rsm) nh = 1'b0;
    @(posedge i_clk);
    #1;
    m_word = nw; m_lrt = nl; m_halt = nh;
    chk("ctrl_word", dut_w, m_word);
    chk("halted", {17'b0, o_halted}, {17'b0, m_halt});
    @(negedge i_clk);
  endtask

  logic       hz;
  logic [5:0] rop, rfn;

  initial begin
    build_table();
    model_reset();
    i_reset_n = 1'b0; i_valid = 1'b1; i_opcode = 6'b100011; i_funct = '0;
    i_rs = 5'd1; i_rt = 5'd2; i_stall = 1'b0; i_flush = 1'b0; i_resume = 1'b0;

    // Reset held with a valid load on the inputs.
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk("reset_word", dut_w, 18'h0);
    chk("reset_halted", {17'b0, o_halted}, 18'h0);
    chk("reset_hazard", {17'b0, o_hazard_stall}, 18'h0);
    i_reset_n = 1'b1;
    step(1, 6'b100011, 0, 1, 2, 0, 0, 0, hz);
    chk("rst_lw_mem_read", {17'b0, o_mem_read}, 18'd1);
    chk("rst_lw_word_size", {15'b0, o_word_size}, 18'd3);
    chk("rst_lw_mem_to_reg", {17'b0, o_mem_to_reg}, 18'd1);
    chk("rst_lw_valid", {17'b0, o_valid}, 18'd1);

    // Decode sweep with rs=rt=0 so no hazard can fire.
    step(1, 6'b000000, 6'b100000, 0, 0, 0, 0, 0, hz);
    for (int k = 0; k < tab_n; k++) step(1, tab_op[k], 6'h2a, 0, 0, 0, 0, 0, hz);
    step(1, 6'b100101, 0, 0, 0, 0, 0, 0, hz);
    chk("lhu_word_size", {15'b0, o_word_size}, 18'd6);
    chk("lhu_ext", {16'b0, o_ext_mode}, 18'd0);
    step(1, 6'b000011, 0, 0, 0, 0, 0, 0, hz);
    chk("jal_reg_dst", {16'b0, o_reg_dst}, 18'd2);
    chk("jal_link", {17'b0, o_link}, 18'd1);
    step(1, 6'b000000, 6'b001001, 0, 0, 0, 0, 0, hz);
    chk("jalr_bits", {15'b0, o_jump_reg, o_link, o_reg_write}, 18'b111);
    step(1, 6'b001111, 0, 0, 0, 0, 0, 0, hz);
    chk("lui_ext", {16'b0, o_ext_mode}, 18'd2);
    step(1, 6'b010001, 0, 0, 0, 0, 0, 0, hz);
    chk("undef_bubble", {1'b0, dut_w[16:0]}, 18'd0);

    // Load-use: LW rt=5 then ADD rs=5.
    step(1, 6'b100011, 0, 1, 5, 0, 0, 0, hz);
    step(1, 6'b000000, 6'b100000, 5, 6, 0, 0, 0, hz);
    chk("lu_stall", {17'b0, hz}, 18'd1);
    chk("lu_bubble", {17'b0, o_valid}, 18'd0);
    step(1, 6'b000000, 6'b100000, 5, 6, 0, 0, 0, hz);
    chk("lu_no_restall", {17'b0, hz}, 18'd0);
    chk("lu_add_rw", {16'b0, o_valid, o_reg_write}, 18'b11);
    step(1, 6'b100011, 0, 1, 0, 0, 0, 0, hz);
    step(1, 6'b000000, 6'b100000, 0, 0, 0, 0, 0, hz);
    chk("lu_rt0_no_stall", {17'b0, hz}, 18'd0);

    // Stall hold then stall+flush.
    step(1, 6'b001000, 0, 1, 2, 0, 0, 0, hz);
    for (int k = 0; k < 3; k++) begin
      step(1, 6'b101011, 0, 3, 4, 1, 0, 0, hz);
      chk("stall_hold", dut_w, {1'b1, 17'b1_00_1_0_0_0_0_0_0_0_0_00_000});
    end
    step(1, 6'b001000, 0, 1, 2, 1, 1, 0, hz);
    chk("stall_flush_bubble", {17'b0, o_valid}, 18'd0);
    step(1, 6'b111111, 0, 0, 0, 0, 1, 0, hz);
    chk("flush_beats_halt", {17'b0, o_halted}, 18'd0);

    // HALT, ten cycles of bubbles, resume.
    step(1, 6'b111111, 0, 0, 0, 0, 0, 0, hz);
    chk("halt_enter", {16'b0, o_halted, o_valid}, 18'b10);
    for (int k = 0; k < 10; k++) begin
      step(1, 6'b001000, 0, 1, 2, 0, 0, 0, hz);
      chk("halt_bubble", {16'b0, o_halted, o_valid}, 18'b10);
    end
    step(1, 6'b001000, 0, 1, 2, 0, 0, 1, hz);
    chk("resume_halted", {17'b0, o_halted}, 18'd0);
    step(1, 6'b001000, 0, 1, 2, 0, 0, 0, hz);
    chk("resume_addi", {16'b0, o_valid, o_alu_src}, 18'b11);

    // Async reset while halted and stalled.
    step(1, 6'b111111, 0, 0, 0, 0, 0, 0, hz);
    i_stall = 1'b1;
    #2;
    i_reset_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_word", dut_w, 18'h0);
    chk("async_rst_halted", {17'b0, o_halted}, 18'h0);
    #1;
    i_reset_n = 1'b1;
    @(negedge i_clk);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      case ($urandom_range(0, 9))
        0, 1:    rop = 6'b000000;
        2:       rop = ($urandom_range(0, 19) == 0) ? 6'b111111 : 6'b010001;
        default: rop = tab_op[$urandom_range(0, tab_n - 1)];
      endcase
      case ($urandom_range(0, 3))
        0:       rfn = 6'b001000;
        1:       rfn = 6'b001001;
        default: rfn = 6'($urandom);
      endcase
      step(($urandom_range(0, 99) < 85), rop, rfn, 5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 20), hz);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit_pipe.md
Name: control_unit_pipe

Overview:
- Registered successor of the decode-stage control unit.
- Decodes opcode/funct into a full control bundle for the extended MIPS subset (loads/stores of all sizes, BNE, JAL/JR/JALR, LUI, HALT) and registers it as the ID/EX control word.
- Adds stall hold, flush bubble, internal load-use hazard detection and a HALT/resume state machine used by the debug unit.

Parameters:
- NB_OP, 6, opcode width.
- NB_FUNCT, 6, funct width.
- NB_REG, 5, register-address width.
- HALT_OPCODE, 6'b111111, opcode that halts the pipeline.
- HAZARD_EN, 1, 1 enables internal load-use detection; 0 forces o_hazard_stall=0.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset_n  in  1  asynchronous active-low reset.
- i_valid  in  1  ID holds a real instruction.
- i_opcode  in  NB_OP  instruction[31:26].
- i_funct  in  NB_FUNCT  instruction[5:0].
- i_rs  in  NB_REG  instruction[25:21].
- i_rt  in  NB_REG  instruction[20:16].
- i_stall  in  1  external stall: hold registered word.
- i_flush  in  1  insert bubble (branch/jump taken).
- i_resume  in  1  leave HALT state.
- o_valid  out  1  registered word is a real instruction.
- o_alu_src  out  1  0=rt, 1=immediate.
- o_reg_dst  out  2  00=rt, 01=rd, 10=r31.
- o_reg_write  out  1  register write enable.
- o_mem_read  out  1  memory read enable.
- o_mem_write  out  1  memory write enable.
- o_mem_to_reg  out  1  writeback selects memory data.
- o_beq  out  1  branch if equal.
- o_bne  out  1  branch if not equal.
- o_jump  out  1  J/JAL.
- o_jump_reg  out  1  JR/JALR.
- o_link  out  1  write PC+8.
- o_ext_mode  out  2  00=signed, 01=zero, 10=LUI (imm<<16).
- o_word_size  out  3  [1:0]: 00=none, 01=byte, 10=half, 11=word; [2]=unsigned load.
- o_hazard_stall  out  1  combinational; PC/IF-ID must hold.
- o_halted  out  1  FSM in HALT.

Behaviour:
- Reset (async, i_reset_n=0): every registered output and internal register = 0; FSM=RUN; o_hazard_stall=0.
- Decode (combinational, next word):
  - R-type 000000: reg_dst=01, reg_write=1.
    - funct 001000 (JR): jump_reg=1, reg_write=0.
    - funct 001001 (JALR): jump_reg=1, link=1, reg_write=1, reg_dst=01.
  - ADDI 001000, SLTI 001010: alu_src=1, ext=00, reg_write=1.
  - ANDI 001100, ORI 001101, XORI 001110: alu_src=1, ext=01, reg_write=1.
  - LUI 001111: alu_src=1, ext=10, reg_write=1.
  - Loads: alu_src=1, mem_read=1, mem_to_reg=1, reg_write=1.
    - LB 100000: word_size=001. LH 100001: 010. LW 100011: 011. LBU 100100: 101. LHU 100101: 110.
  - Stores: alu_src=1, mem_write=1.
    - SB 101000: word_size=001. SH 101001: 010. SW 101011: 011.
  - BEQ 000100: beq=1. BNE 000101: bne=1.
  - J 000010: jump=1. JAL 000011: jump=1, link=1, reg_write=1, reg_dst=10.
  - Any other opcode: all-zero bubble word.
  - All fields not listed are 0.
- Register update (one-cycle latency), priority highest first:
  - (1) i_flush: load bubble (all 0, o_valid=0).
  - (2) o_hazard_stall: load bubble.
  - (3) i_stall: hold all outputs.
  - (4) FSM=HALT: load bubble.
  - (5) otherwise: load decoded word, o_valid=i_valid. If i_valid=0, load a bubble.
- Load-use hazard:
  - Internal r_load_rt is captured with the word whenever one is loaded.
  - o_hazard_stall=1 when HAZARD_EN, o_valid, o_mem_read, r_load_rt!=0, i_valid, FSM=RUN, and r_load_rt==i_rs.
  - It also fires when r_load_rt==i_rt and the current opcode reads rt (R-type, BEQ, BNE, stores).
  - Asserted for exactly one cycle per load; the bubble clears o_mem_read, which drops the stall.
- FSM RUN/HALT:
  - RUN→HALT on a clock edge where i_valid, opcode==HALT_OPCODE, and neither flush, hazard nor stall is active. The HALT word itself loads as a bubble.
  - HALT→RUN when i_resume=1.
  - In HALT: o_halted=1, bubbles issued, o_hazard_stall=0.
  - i_flush in HALT issues a bubble and leaves the state unchanged.
- Simultaneous events:
  - flush+stall: bubble.
  - HALT opcode with i_flush: flushed, no halt.
  - i_resume in RUN: ignored.
- Reset asserted mid-operation: outputs clear immediately (asynchronous), FSM=RUN, no recovery cycle needed.

Test Plan:
- Reset: hold i_reset_n=0 with i_valid=1, opcode=100011 → all outputs 0; release → the next edge gives o_mem_read=1, o_word_size=011, o_mem_to_reg=1, o_valid=1.
- Decode sweep: for each listed opcode/funct (including JAL, JALR, LUI, LHU, SB, BNE), one edge later the registered bundle matches the table, e.g. LHU → word_size=110, ext=00; JAL → reg_dst=10, link=1.
- Load-use: LW with rt=5, then ADD with rs=5 → o_hazard_stall=1 for one cycle and the next word is a bubble; on the following cycle ADD registers with reg_write=1. Repeat with rt=0 → no stall.
- Stall/flush priority: set i_stall=1 for 3 cycles → outputs constant; then i_stall=1 with i_flush=1 → bubble (o_valid=0).
- HALT: opcode 111111 → o_halted=1 and bubbles for 10 cycles despite valid ADDI input; pulse i_resume → o_halted=0 and ADDI registers on the next edge.
- Async reset while in HALT mid-stall → immediate all-zero outputs with o_halted=0.
